// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type, iteration count and a small operand helper.
package md_pkg;

  localparam int MD_ITER = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_t;

  // Two's-complement negate when neg is set, otherwise pass through.
  function automatic logic [31:0] md_cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iteration datapath: a 64-bit accumulator that performs one shift-add
// multiply step or one restoring-divide step per step_en, plus the step counter.
// Multiply: acc = {partial, multiplicand}, product ends in acc.
// Divide:   acc = {remainder, dividend/quotient}, quotient bits enter at bit 0.
module md_iter_core
  import md_pkg::*;
#(
  parameter int ITER = MD_ITER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step_en,
  input  logic        div_mode,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [63:0] acc,
  output logic        last
);

  logic [63:0] acc_r;
  logic [63:0] acc_next_s;
  logic [31:0] b_r;
  logic [5:0]  cnt_r;
  logic [32:0] mul_sum_s;
  logic [33:0] div_trial_s;

  // Next accumulator value for one multiply or one divide step.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, b_r} : 33'd0);
    // The shifted partial remainder needs 33 bits; the extra top bit of the
    // trial result is the borrow that decides restore vs. keep.
    div_trial_s = {1'b0, acc_r[63:31]} - {2'b00, b_r};
    if (div_mode) begin
      if (!div_trial_s[33]) begin
        acc_next_s = {div_trial_s[31:0], acc_r[30:0], 1'b1};
      end else begin
        acc_next_s = {acc_r[62:0], 1'b0};
      end
    end else begin
      acc_next_s = {mul_sum_s, acc_r[31:1]};
    end
  end

  // Accumulator, operand-b and step counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_r <= 64'd0;
      b_r   <= 32'd0;
      cnt_r <= 6'd0;
    end else if (load) begin
      acc_r <= {32'd0, op_a};
      b_r   <= op_b;
      cnt_r <= 6'd0;
    end else if (step_en) begin
      acc_r <= acc_next_s;
      cnt_r <= cnt_r + 6'd1;
    end else begin
      acc_r <= acc_r;
      b_r   <= b_r;
      cnt_r <= cnt_r;
    end
  end

  assign acc  = acc_r;
  assign last = (cnt_r == 6'(ITER - 1));

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit: FSM, operand sign handling, special cases
// and the HI/LO result registers around the md_iter_core datapath.
module muldiv_unit
  import md_pkg::*;
#(
  parameter int ITER = MD_ITER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        cancel,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_t   state_r, state_next_s;
  logic [1:0]  op_r;
  logic        a_neg_r, b_neg_r, b_zero_r;
  logic [31:0] a_raw_r;
  logic [31:0] hi_r, lo_r;
  logic        load_s, step_s, last_s;
  logic        signed_op_s, a_neg_s, b_neg_s;
  logic [31:0] a_mag_s, b_mag_s;
  logic [63:0] acc_s, prod_s;
  logic [31:0] res_hi_s, res_lo_s;

  assign signed_op_s = !op[0];
  assign a_neg_s     = signed_op_s && src_a[31];
  assign b_neg_s     = signed_op_s && src_b[31];
  assign a_mag_s     = md_cond_neg32(src_a, a_neg_s);
  assign b_mag_s     = md_cond_neg32(src_b, b_neg_s);

  assign load_s = (state_r == MD_IDLE) && start && !cancel;
  assign step_s = (state_r == MD_RUN) && !cancel;

  md_iter_core #(.ITER(ITER)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .step_en  (step_s),
    .div_mode (op_r[1]),
    .op_a     (a_mag_s),
    .op_b     (b_mag_s),
    .acc      (acc_s),
    .last     (last_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= MD_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; cancel returns to IDLE from any state.
  always_comb begin
    state_next_s = state_r;
    if (cancel) begin
      state_next_s = MD_IDLE;
    end else begin
      case (state_r)
        MD_IDLE: begin
          if (start) begin
            state_next_s = MD_RUN;
          end else begin
            state_next_s = MD_IDLE;
          end
        end
        MD_RUN: begin
          if (last_s) begin
            state_next_s = MD_DONE;
          end else begin
            state_next_s = MD_RUN;
          end
        end
        MD_DONE: state_next_s = MD_IDLE;
        default: state_next_s = MD_IDLE;
      endcase
    end
  end

  // Operand attributes captured when a request is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_r     <= 2'b00;
      a_neg_r  <= 1'b0;
      b_neg_r  <= 1'b0;
      b_zero_r <= 1'b0;
      a_raw_r  <= 32'd0;
    end else if (load_s) begin
      op_r     <= op;
      a_neg_r  <= a_neg_s;
      b_neg_r  <= b_neg_s;
      b_zero_r <= (src_b == 32'd0);
      a_raw_r  <= src_a;
    end else begin
      op_r     <= op_r;
      a_neg_r  <= a_neg_r;
      b_neg_r  <= b_neg_r;
      b_zero_r <= b_zero_r;
      a_raw_r  <= a_raw_r;
    end
  end

  // Sign correction and special cases applied to the magnitude result.
  // 0x8000_0000 / -1 needs no special path: |q| = 0x8000_0000 negates to itself.
  always_comb begin
    prod_s   = acc_s;
    res_hi_s = acc_s[63:32];
    res_lo_s = acc_s[31:0];
    if (op_r[1]) begin
      if (b_zero_r) begin
        res_hi_s = a_raw_r;
        res_lo_s = 32'hFFFF_FFFF;
      end else begin
        res_hi_s = md_cond_neg32(acc_s[63:32], a_neg_r);
        res_lo_s = md_cond_neg32(acc_s[31:0], a_neg_r ^ b_neg_r);
      end
    end else begin
      prod_s   = (a_neg_r ^ b_neg_r) ? (64'd0 - acc_s) : acc_s;
      res_hi_s = prod_s[63:32];
      res_lo_s = prod_s[31:0];
    end
  end

  // HI/LO registers: written at the end of DONE unless the op is flushed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if ((state_r == MD_DONE) && !cancel) begin
      hi_r <= res_hi_s;
      lo_r <= res_lo_s;
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  assign busy = load_s || (state_r == MD_RUN);
  assign done = (state_r == MD_DONE);
  assign hi   = ((state_r == MD_DONE) && !cancel) ? res_hi_s : hi_r;
  assign lo   = ((state_r == MD_DONE) && !cancel) ? res_lo_s : lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard testbench for muldiv_unit: stimulus pushes expected HI/LO and
// issue cycle; a monitor pops and compares on every done pulse.
module tb_muldiv_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        cancel = 1'b0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .cancel (cancel),
    .src_a  (src_a),
    .src_b  (src_b),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference behaviour from the arithmetic definition of each op.
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] eh, output logic [31:0] el);
    logic [63:0] p;
    p = 64'd0;
    eh = 32'd0;
    el = 32'd0;
    case (o)
      MD_MULT: begin
        p  = 64'($signed(a)) * 64'($signed(b));
        eh = p[63:32];
        el = p[31:0];
      end
      MD_MULTU: begin
        p  = {32'd0, a} * {32'd0, b};
        eh = p[63:32];
        el = p[31:0];
      end
      MD_DIV: begin
        if (b == 32'd0) begin
          el = 32'hFFFF_FFFF;
          eh = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          el = 32'h8000_0000;
          eh = 32'd0;
        end else begin
          el = $signed(a) / $signed(b);
          eh = $signed(a) % $signed(b);
        end
      end
      default: begin
        if (b == 32'd0) begin
          el = 32'hFFFF_FFFF;
          eh = a;
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
    endcase
  endfunction

  // Monitor: compare every done pulse against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      model_hi = 32'd0;
      model_lo = 32'd0;
    end else if (done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 with no request outstanding, expected done=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("done_latency", 64'(cyc), 64'(e.cyc + 33));
        check("hi", {32'd0, hi}, {32'd0, e.hi});
        check("lo", {32'd0, lo}, {32'd0, e.lo});
        model_hi = e.hi;
        model_lo = e.lo;
      end
    end
  end

  // One operation from cycle 0 (start) through cycle 35; optional cancel,
  // reset or spurious restart at a given relative cycle (-1 = none).
  // Called just after an active edge with the unit idle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int cancel_at, input int rst_at, input int restart_at);
    logic [31:0] eh, el;
    exp_t e;
    int   abort_at;
    bit   exp_busy;
    abort_at = (cancel_at >= 0) ? cancel_at : rst_at;
    ref_model(o, a, b, eh, el);
    if (abort_at < 0) begin
      e.hi = eh;
      e.lo = el;
      e.cyc = cyc;
      sb.push_back(e);
    end
    for (int k = 0; k < 36; k++) begin
      start  = (k == 0) || (k == restart_at);
      cancel = (k == cancel_at);
      rst    = (k != rst_at);
      if (k == 0) begin
        op = o; src_a = a; src_b = b;
      end else begin
        op = 2'($urandom_range(0, 3)); src_a = $urandom; src_b = $urandom;
      end
      @(negedge clk);
      exp_busy = (k <= 32) && (abort_at < 0 || k <= abort_at);
      check("busy", {63'd0, busy}, {63'd0, exp_busy});
      if (rst_at >= 0 && k == rst_at + 1) begin
        check("hi_after_reset", {32'd0, hi}, 64'd0);
        check("lo_after_reset", {32'd0, lo}, 64'd0);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0; cancel = 1'b0; rst = 1'b1;
    check("no_pending_done", 64'(sb.size()), 64'd0);
    sb.delete();
    if (abort_at >= 0) begin
      check("hi_hold", {32'd0, hi}, {32'd0, model_hi});
      check("lo_hold", {32'd0, lo}, {32'd0, model_lo});
    end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [5];
    specials[0] = 32'd0;
    specials[1] = 32'd1;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000;
    specials[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    else if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 1000));
    else return $urandom;
  endfunction

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    run_op(MD_MULT,  32'hFFFF_FFFF, 32'd2, -1, -1, -1);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, -1, -1, -1);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, -1, -1, -1);
    run_op(MD_DIVU,  32'd100, 32'd7, -1, -1, -1);
    run_op(MD_DIVU,  32'd5, 32'd0, -1, -1, -1);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
    run_op(MD_DIVU,  32'd100, 32'd7, -1, -1, -1);
    // Flushed MULT: hi/lo must keep the 2/14 from the divide above.
    run_op(MD_MULT,  32'd3, 32'd4, 10, -1, -1);

    // start together with cancel in IDLE is ignored.
    start = 1'b1; cancel = 1'b1; op = MD_MULT; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    check("start_with_cancel_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0;
    repeat (36) @(posedge clk);
    #1;
    check("start_with_cancel_hi", {32'd0, hi}, {32'd0, model_hi});
    check("start_with_cancel_lo", {32'd0, lo}, {32'd0, model_lo});

    // Reset in cycle 15 of a MULT.
    run_op(MD_MULT, 32'd12345, 32'd678, -1, 15, -1);
    // Spurious start in cycle 5 is ignored.
    run_op(MD_MULT, 32'hDEAD_BEEF, 32'h1234_5678, -1, -1, 5);
    run_op(MD_DIV,  32'h8000_0001, 32'd3, -1, -1, 7);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick_operand();
      rb = pick_operand();
      if (ro == MD_DIV && rb == 32'd0) rb = 32'd1;
      run_op(ro, ra, rb, -1, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the EX stage of the 5-stage MIPS core. It accepts MULT/MULTU/DIV/DIVU requests from the ID/EX register's `start` strobe and computes a 64-bit result over 32 iteration cycles. It holds `busy` so hazard control can freeze the PC, IF/ID, ID/EX and EX/MEM write enables. It drops the HI/LO result onto `hi`/`lo` for the RHL write path into EX/MEM.

## Interface
Parameters:
- `ITER`, default 32: number of iteration cycles, one bit per cycle. Only 32 is supported.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `start`  in  1  request strobe, sampled only in IDLE
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `cancel`  in  1  exception/eret flush of EX; aborts any operation
- `src_a`  in  32  rs operand (multiplicand / dividend)
- `src_b`  in  32  rt operand (multiplier / divisor)
- `busy`  out  1  pipeline stall request
- `done`  out  1  one-cycle pulse; `hi`/`lo` are newly valid
- `hi`  out  32  MULT: product[63:32]; DIV: remainder
- `lo`  out  32  MULT: product[31:0]; DIV: quotient

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start && !cancel`: latch |a|, |b| (signed ops) or raw operands (unsigned ops), latch `op`, latch result signs, clear counter → RUN.
- RUN:
  - Multiply: shift-add, one multiplier bit per cycle.
  - Divide: restoring, one quotient bit per cycle.
  - After 32 iterations → DONE.
- DONE:
  - Apply sign correction and write `hi`/`lo`.
  - Assert `done` → IDLE.
- Sign rules:
  - Product sign = sign(a) ^ sign(b).
  - Quotient sign = sign(a) ^ sign(b).
  - Remainder sign = sign(a).
  - Unsigned ops ignore sign bits.
- Divide by zero: `lo`=32'hFFFF_FFFF, `hi`=src_a (as latched), no exception. Takes the full latency.
- Signed 0x8000_0000 / 0xFFFF_FFFF: `lo`=32'h8000_0000, `hi`=0.
- `cancel` in any state:
  - → IDLE next edge.
  - No `done`.
  - `hi`/`lo` unchanged.
  - `cancel` has priority over `start` in the same cycle.
- `start` while in RUN or DONE is ignored. The pipeline is stalled, so it is held; no queuing.
- `hi`/`lo` hold their last value until the next DONE.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0, internal registers 0.
- Reset mid-operation behaves like `cancel`, and additionally clears `hi`/`lo`.
- Cycle numbering: `start` high in cycle 0 (IDLE).
  - Cycles 1–32: RUN.
  - Cycle 33: DONE, `done`=1, `hi`/`lo` valid from the edge ending cycle 33. They are readable combinationally during cycle 33 from the DONE-stage registers, and registered thereafter.
  - Fixed latency for every op and every operand value.
- `busy` = (IDLE && `start` && !`cancel`) || RUN.
  - Combinational from `start`, so the issuing cycle stalls too.
  - Low in DONE, which lets the instruction advance in cycle 33.
- `done` is registered-state-derived only and never combinational from inputs.
- Back-to-back: a new `start` is accepted in cycle 34 at the earliest.

## Structure
- Shared package `md_pkg`:
  - op encodings `MD_MULT`/`MD_MULTU`/`MD_DIV`/`MD_DIVU`
  - state enum `md_state_t`
  - `MD_ITER` = 32
- One sub-module, `md_iter_core`: a 64-bit accumulator/shift datapath plus a 6-bit counter. It performs one step per `step_en` in mul or div mode.
- The top level owns the FSM, sign handling, special cases and the `hi`/`lo` registers.

## Test plan
- MULT a=0xFFFF_FFFF, b=2 → `done` in cycle 33, `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFFE; `busy`=1 in cycles 0–32, 0 in cycle 33.
- MULTU a=0xFFFF_FFFF, b=2 → `hi`=0x0000_0001, `lo`=0xFFFF_FFFE.
- DIV a=-7 (0xFFFF_FFF9), b=2 → `lo`=0xFFFF_FFFD, `hi`=0xFFFF_FFFF. DIVU a=100, b=7 → `lo`=14, `hi`=2.
- DIVU a=5, b=0 → `lo`=0xFFFF_FFFF, `hi`=5. DIV 0x8000_0000 / 0xFFFF_FFFF → `lo`=0x8000_0000, `hi`=0.
- DIVU 100/7 completes with `hi`=2; then MULT 3×4 with `cancel` in cycle 10 → `busy`=0 from cycle 11, no `done`, `hi`/`lo` stay 2/14. A `start` together with `cancel` in IDLE is ignored.
- `rst`=0 in cycle 15 of a MULT → next cycle IDLE, `hi`=`lo`=0, `busy`=0. A `start` pulsed again in cycle 5 of a running op leaves the result and latency unchanged.
